fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Forwarding and load-use hazard controller for the five-stage pipeline. It keeps its own shadow copy of the destination information for the EX/MEM and MEM/WB stages. From that copy it produces the ALUSrcA/B/H/L bypass selects that the execute stage consumes, plus the stall and bubble controls for the IF/ID and ID/EX registers. It sits beside the ID/EX register and is driven directly by decode-stage and execute-stage control fields.

## Interface
- No parameters.
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ID_Rs  in  5  rs field of the instruction in ID.
- ID_Rt  in  5  rt field of the instruction in ID.
- ID_UseRs  in  1  ID instruction reads rs.
- ID_UseRt  in  1  ID instruction reads rt (including store data).
- EX_Rs  in  5  rs of the instruction in EX.
- EX_Rt  in  5  rt of the instruction in EX.
- EX_Rw  in  5  destination register chosen in EX (0 for stores).
- EX_RegWr  in  1  EX instruction writes the register file.
- EX_MemtoReg  in  1  EX instruction is a load.
- EX_HiWr  in  1  EX instruction writes HI.
- EX_LoWr  in  1  EX instruction writes LO.
- ALUSrcA  out  2  BusA select: 00 register file, 01 EX/MEM result, 10 WB bus.
- ALUSrcB  out  2  BusB/store-data select, same encoding.
- ALUSrcH  out  2  HI select: 00 HI register, 01 EX/MEM HiRe, 10 MEM/WB HiRe.
- ALUSrcL  out  2  LO select, same encoding for LoRe.
- Stall  out  1  hold PC and IF/ID this cycle.
- Bubble  out  1  load NOP into ID/EX this cycle.
- StallCnt  out  32  count of load-use stall cycles since reset.

## Operation
- Shadow stage M (EX/MEM) holds Rw, RegWr, MemtoReg, HiWr and LoWr.
  - It samples the EX_* inputs every cycle.
- Shadow stage W (MEM/WB) holds Rw, RegWr, HiWr and LoWr.
  - It samples stage M every cycle.
  - Neither stage has an enable: a bubble arrives as EX_RegWr=0 from the ID/EX register.
- ALUSrcA (combinational):
  - 01 if M.RegWr & !M.MemtoReg & M.Rw!=0 & M.Rw==EX_Rs;
  - else 10 if W.RegWr & W.Rw!=0 & W.Rw==EX_Rs;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- ALUSrcB: same rule using EX_Rt.
- Register 0 never forwards.
- A load in stage M never yields 01, because the address is not the data.
- ALUSrcH: 01 if M.HiWr, else 10 if W.HiWr, else 00. ALUSrcL uses LoWr in the same way. Code 11 is never driven.
- Load-use hazard condition:
  - EX_MemtoReg & EX_RegWr & EX_Rw!=0, and
  - (ID_UseRs & ID_Rs==EX_Rw) or (ID_UseRt & ID_Rt==EX_Rw).
- FSM states: RUN and LSTALL.
  - RUN: when the hazard condition holds, assert Stall=Bubble=1 and go to LSTALL. Otherwise Stall=Bubble=0 and stay in RUN.
  - LSTALL: Stall=Bubble=0 unconditionally and return to RUN. The load is now in MEM and will be bypassed by select 10 one cycle later. EX holds the bubble, so re-detection against it is suppressed.
- StallCnt increments by 1 on every cycle with Stall=1 and wraps modulo 2^32.

## Timing
- ALUSrc*, Stall and Bubble are combinational from the current inputs and registered state, valid in the same cycle. The unit adds no latency.
- Shadow stages and the FSM update on the rising edge of Clk.
- Reset values:
  - All shadow fields 0; FSM = RUN; StallCnt = 0.
  - Outputs: ALUSrcA/B/H/L = 00, Stall = 0, Bubble = 0.
  - Reset dominates any simultaneous hazard.
- A load-use stall lasts exactly one cycle. Back-to-back dependent loads each cost one cycle.
- A consumer that needs both operands from the same load costs one stall, not two.
- Reset asserted during LSTALL: the next state is RUN with shadows cleared, so no stray forward follows.

## Structure
- Shared pipeline package holds:
  - the select encodings SRC_REG=2'b00, SRC_EXMEM=2'b01 and SRC_WB=2'b10;
  - the FSM state constants.
- Sub-module fwd_sel handles one operand's compare-and-priority logic. It is instantiated for A and B; H and L reuse it with compare disabled.

## Test plan
- `add $3,$1,$2` followed by `sub $4,$3,$5` → during sub's EX, ALUSrcA=01 and ALUSrcB=00.
- `add $3,..`, then an unrelated instruction, then `or $6,$7,$3` → ALUSrcB=10 during or's EX.
- Writes to $3 in both M and W, with EX reading $3 → ALUSrcA=01 (priority). Repeat with $0 as the destination → 00.
- `lw $8,0($9)` followed by `add $10,$8,$8`:
  - Stall=Bubble=1 for exactly one cycle and StallCnt=1;
  - next cycle Stall=0;
  - during add's EX, ALUSrcA=ALUSrcB=10.
- `mthi` followed by `mfhi` → ALUSrcH=01. `mtlo`, a NOP, then `mflo` → ALUSrcL=10.
- Reset pulsed in the cycle after Stall=1 → all outputs 00/0 and StallCnt=0 on the next cycle.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding / load-use hazard unit.
// Holds the bypass select encodings and the hazard FSM state type.
package fwd_hazard_unit_pkg;

   localparam logic [1:0] SRC_REG   = 2'b00;
   localparam logic [1:0] SRC_EXMEM = 2'b01;
   localparam logic [1:0] SRC_WB    = 2'b10;

   typedef enum logic {
      RUN    = 1'b0,
      LSTALL = 1'b1
   } fsm_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode/execute control fields into the hazard unit and the bypass/stall
// controls back out.
//   ID_Rs/ID_Rt/ID_UseRs/ID_UseRt : source operands of the instruction in ID
//   EX_Rs/EX_Rt/EX_Rw             : sources and destination of the EX instruction
//   EX_RegWr/EX_MemtoReg          : EX writes the register file / is a load
//   EX_HiWr/EX_LoWr               : EX writes HI / LO
//   ALUSrcA/B/H/L                 : bypass selects for the execute stage
//   Stall/Bubble                  : hold PC and IF/ID, insert a NOP into ID/EX
//   StallCnt                      : load-use stall cycles since reset
// master drives the pipeline fields, slave is the hazard unit.
interface fwd_hazard_unit_if;
   logic [4:0]  ID_Rs;
   logic [4:0]  ID_Rt;
   logic        ID_UseRs;
   logic        ID_UseRt;
   logic [4:0]  EX_Rs;
   logic [4:0]  EX_Rt;
   logic [4:0]  EX_Rw;
   logic        EX_RegWr;
   logic        EX_MemtoReg;
   logic        EX_HiWr;
   logic        EX_LoWr;
   logic [1:0]  ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUSrcH;
   logic [1:0]  ALUSrcL;
   logic        Stall;
   logic        Bubble;
   logic [31:0] StallCnt;

   modport master (
      output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
      output EX_Rs, EX_Rt, EX_Rw, EX_RegWr, EX_MemtoReg, EX_HiWr, EX_LoWr,
      input  ALUSrcA, ALUSrcB, ALUSrcH, ALUSrcL, Stall, Bubble, StallCnt
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
      input  EX_Rs, EX_Rt, EX_Rw, EX_RegWr, EX_MemtoReg, EX_HiWr, EX_LoWr,
      output ALUSrcA, ALUSrcB, ALUSrcH, ALUSrcL, Stall, Bubble, StallCnt
   );
endinterface

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Compare-and-priority bypass select for one operand.
//   cmp_en : 1 = match src against the stage destinations (GPR operands),
//            0 = a stage write alone selects it (HI/LO)
//   src    : register number read in EX
//   m_wr, m_rw : EX/MEM stage may forward, and its destination
//   w_wr, w_rw : MEM/WB stage may forward, and its destination
//   sel    : SRC_REG / SRC_EXMEM / SRC_WB, EX/MEM taking priority
module fwd_hazard_unit_fwd_sel
   import fwd_hazard_unit_pkg::*;
(
   input  logic       cmp_en,
   input  logic [4:0] src,
   input  logic       m_wr,
   input  logic [4:0] m_rw,
   input  logic       w_wr,
   input  logic [4:0] w_rw,
   output logic [1:0] sel
);

   logic m_match;
   logic w_match;

   // Register 0 is hard-wired, so a write to it must never be bypassed.
   assign m_match = cmp_en ? ((m_rw != 5'd0) && (m_rw == src)) : 1'b1;
   assign w_match = cmp_en ? ((w_rw != 5'd0) && (w_rw == src)) : 1'b1;

   always_comb begin
      sel = SRC_REG;
      if (m_wr && m_match) begin
         sel = SRC_EXMEM;
      end else if (w_wr && w_match) begin
         sel = SRC_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the five-stage pipeline.
// Keeps shadow copies of the EX/MEM and MEM/WB destination fields and from
// them produces the execute-stage bypass selects plus the IF/ID stall and
// ID/EX bubble controls.
//   Clk   : pipeline clock
//   Reset : synchronous, active-high
//   bus   : decode/execute fields in, selects / Stall / Bubble / StallCnt out
//
// state  | meaning
// RUN    | normal flow; a load-use hazard stalls for one cycle
// LSTALL | bubble sits in EX, load is in MEM; no stall, no re-detection
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   fwd_hazard_unit_if.slave  bus
);

   logic [4:0]  m_rw;
   logic        m_regwr;
   logic        m_memtoreg;
   logic        m_hiwr;
   logic        m_lowr;
   logic [4:0]  w_rw;
   logic        w_regwr;
   logic        w_hiwr;
   logic        w_lowr;

   fsm_state_t  state_q;
   fsm_state_t  state_d;
   logic        hazard;
   logic        stall;
   logic [31:0] stall_cnt;

   // Shadow pipeline; bubbles arrive as EX_RegWr=0 so no enable is needed.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         m_rw       <= 5'd0;
         m_regwr    <= 1'b0;
         m_memtoreg <= 1'b0;
         m_hiwr     <= 1'b0;
         m_lowr     <= 1'b0;
         w_rw       <= 5'd0;
         w_regwr    <= 1'b0;
         w_hiwr     <= 1'b0;
         w_lowr     <= 1'b0;
      end else begin
         m_rw       <= bus.EX_Rw;
         m_regwr    <= bus.EX_RegWr;
         m_memtoreg <= bus.EX_MemtoReg;
         m_hiwr     <= bus.EX_HiWr;
         m_lowr     <= bus.EX_LoWr;
         w_rw       <= m_rw;
         w_regwr    <= m_regwr;
         w_hiwr     <= m_hiwr;
         w_lowr     <= m_lowr;
      end
   end

   // A load in EX/MEM only has its address, so it is not a bypass source.
   fwd_hazard_unit_fwd_sel u_sel_a (
      .cmp_en (1'b1),
      .src    (bus.EX_Rs),
      .m_wr   (m_regwr & ~m_memtoreg),
      .m_rw   (m_rw),
      .w_wr   (w_regwr),
      .w_rw   (w_rw),
      .sel    (bus.ALUSrcA)
   );

   fwd_hazard_unit_fwd_sel u_sel_b (
      .cmp_en (1'b1),
      .src    (bus.EX_Rt),
      .m_wr   (m_regwr & ~m_memtoreg),
      .m_rw   (m_rw),
      .w_wr   (w_regwr),
      .w_rw   (w_rw),
      .sel    (bus.ALUSrcB)
   );

   fwd_hazard_unit_fwd_sel u_sel_h (
      .cmp_en (1'b0),
      .src    (5'd0),
      .m_wr   (m_hiwr),
      .m_rw   (5'd0),
      .w_wr   (w_hiwr),
      .w_rw   (5'd0),
      .sel    (bus.ALUSrcH)
   );

   fwd_hazard_unit_fwd_sel u_sel_l (
      .cmp_en (1'b0),
      .src    (5'd0),
      .m_wr   (m_lowr),
      .m_rw   (5'd0),
      .w_wr   (w_lowr),
      .w_rw   (5'd0),
      .sel    (bus.ALUSrcL)
   );

   assign hazard = bus.EX_MemtoReg && bus.EX_RegWr && (bus.EX_Rw != 5'd0) &&
                   ((bus.ID_UseRs && (bus.ID_Rs == bus.EX_Rw)) ||
                    (bus.ID_UseRt && (bus.ID_Rt == bus.EX_Rw)));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Reset masks the stall so a simultaneous hazard never reaches the pipe.
   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         RUN: begin
            if (hazard && !Reset) begin
               stall   = 1'b1;
               state_d = LSTALL;
            end
         end
         LSTALL: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stall_cnt <= 32'd0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.Stall    = stall;
   assign bus.Bubble   = stall;
   assign bus.StallCnt = stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
   import fwd_hazard_unit_pkg::*;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] exp_cnt = 32'd0;

   fwd_hazard_unit_if bus();

   fwd_hazard_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_ex(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                         input logic regwr, input logic memtoreg,
                         input logic hiwr, input logic lowr);
      bus.EX_Rs       = rs;
      bus.EX_Rt       = rt;
      bus.EX_Rw       = rw;
      bus.EX_RegWr    = regwr;
      bus.EX_MemtoReg = memtoreg;
      bus.EX_HiWr     = hiwr;
      bus.EX_LoWr     = lowr;
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                         input logic use_rs, input logic use_rt);
      bus.ID_Rs    = rs;
      bus.ID_Rt    = rt;
      bus.ID_UseRs = use_rs;
      bus.ID_UseRt = use_rt;
   endtask

   task automatic clear_inputs();
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      set_ex(5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
      set_id(5'd8, 5'd8, 1'b1, 1'b1);
      #1;
      checks++;
      if (bus.Stall !== 1'b0) begin
         errors++; $display("FAIL reset_masks_stall: got %b want 0", bus.Stall);
      end
      step();
      step();
      Reset = 1'b0;
      set_ex(5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUSrcH, bus.ALUSrcL} !== 8'h00) begin
         errors++; $display("FAIL reset_selects: got %h want 00",
                            {bus.ALUSrcA, bus.ALUSrcB, bus.ALUSrcH, bus.ALUSrcL});
      end
      checks++;
      if ({bus.Stall, bus.Bubble} !== 2'b00) begin
         errors++; $display("FAIL reset_stall_bubble: got %b want 00", {bus.Stall, bus.Bubble});
      end
      checks++;
      if (bus.StallCnt !== 32'd0) begin
         errors++; $display("FAIL reset_stallcnt: got %0d want 0", bus.StallCnt);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_exmem_fwd();
      set_ex(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.ALUSrcA !== SRC_EXMEM) begin
         errors++; $display("FAIL exmem_a: got %b want 01", bus.ALUSrcA);
      end
      checks++;
      if (bus.ALUSrcB !== SRC_REG) begin
         errors++; $display("FAIL exmem_b: got %b want 00", bus.ALUSrcB);
      end
      step();
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_wb_fwd();
      set_ex(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd11, 5'd13, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.ALUSrcB !== SRC_WB) begin
         errors++; $display("FAIL wb_b: got %b want 10", bus.ALUSrcB);
      end
      checks++;
      if (bus.ALUSrcA !== SRC_REG) begin
         errors++; $display("FAIL wb_a: got %b want 00", bus.ALUSrcA);
      end
      step();
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_priority();
      set_ex(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd3, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.ALUSrcA !== SRC_EXMEM) begin
         errors++; $display("FAIL priority_a: got %b want 01", bus.ALUSrcA);
      end
      checks++;
      if (bus.ALUSrcB !== SRC_EXMEM) begin
         errors++; $display("FAIL priority_b: got %b want 01", bus.ALUSrcB);
      end
      // Same pattern with $0 as destination: never forwarded.
      set_ex(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd4, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB} !== 4'b0000) begin
         errors++; $display("FAIL zero_reg: got %b want 0000", {bus.ALUSrcA, bus.ALUSrcB});
      end
      // Load in EX/MEM is not a bypass source.
      step();
      set_ex(5'd9, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      set_ex(5'd3, 5'd0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.ALUSrcA !== SRC_REG) begin
         errors++; $display("FAIL load_in_m: got %b want 00", bus.ALUSrcA);
      end
      step();
      #1;
      checks++;
      if (bus.ALUSrcA !== SRC_WB) begin
         errors++; $display("FAIL load_in_w: got %b want 10", bus.ALUSrcA);
      end
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_load_use();
      set_ex(5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      set_id(5'd8, 5'd8, 1'b1, 1'b1);
      #1;
      checks++;
      if ({bus.Stall, bus.Bubble} !== 2'b11) begin
         errors++; $display("FAIL lu_stall: got %b want 11", {bus.Stall, bus.Bubble});
      end
      step();
      exp_cnt = exp_cnt + 32'd1;
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (bus.StallCnt !== exp_cnt) begin
         errors++; $display("FAIL lu_count: got %0d want %0d", bus.StallCnt, exp_cnt);
      end
      checks++;
      if ({bus.Stall, bus.Bubble} !== 2'b00) begin
         errors++; $display("FAIL lu_release: got %b want 00", {bus.Stall, bus.Bubble});
      end
      step();
      set_ex(5'd8, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB} !== {SRC_WB, SRC_WB}) begin
         errors++; $display("FAIL lu_bypass: got %b want 1010", {bus.ALUSrcA, bus.ALUSrcB});
      end
      checks++;
      if (bus.Stall !== 1'b0 || bus.StallCnt !== exp_cnt) begin
         errors++; $display("FAIL lu_single: got stall=%b cnt=%0d want stall=0 cnt=%0d",
                            bus.Stall, bus.StallCnt, exp_cnt);
      end
      step();
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_lstall_suppress();
      set_ex(5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      set_id(5'd0, 5'd8, 1'b0, 1'b1);
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
         errors++; $display("FAIL sup_first: got %b want 1", bus.Stall);
      end
      step();
      exp_cnt = exp_cnt + 32'd1;
      #1;
      checks++;
      if (bus.Stall !== 1'b0) begin
         errors++; $display("FAIL sup_lstall: got %b want 0", bus.Stall);
      end
      step();
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
         errors++; $display("FAIL sup_rearm: got %b want 1", bus.Stall);
      end
      step();
      exp_cnt = exp_cnt + 32'd1;
      clear_inputs();
      #1;
      checks++;
      if (bus.StallCnt !== exp_cnt) begin
         errors++; $display("FAIL sup_count: got %0d want %0d", bus.StallCnt, exp_cnt);
      end
      step();
      step();
   endtask

   task automatic test_back_to_back();
      set_ex(5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      set_id(5'd8, 5'd9, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got %b want 1", bus.Stall);
      end
      step();
      exp_cnt = exp_cnt + 32'd1;
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      set_id(5'd9, 5'd2, 1'b1, 1'b1);
      #1;
      checks++;
      if ({bus.Stall, bus.ALUSrcA} !== {1'b1, SRC_WB}) begin
         errors++; $display("FAIL b2b_second: got stall=%b a=%b want stall=1 a=10",
                            bus.Stall, bus.ALUSrcA);
      end
      step();
      exp_cnt = exp_cnt + 32'd1;
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd9, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB, bus.Stall} !== {SRC_WB, SRC_REG, 1'b0}) begin
         errors++; $display("FAIL b2b_consume: got a=%b b=%b stall=%b want a=10 b=00 stall=0",
                            bus.ALUSrcA, bus.ALUSrcB, bus.Stall);
      end
      checks++;
      if (bus.StallCnt !== exp_cnt) begin
         errors++; $display("FAIL b2b_count: got %0d want %0d", bus.StallCnt, exp_cnt);
      end
      step();
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_hilo();
      set_ex(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      set_ex(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({bus.ALUSrcH, bus.ALUSrcL} !== {SRC_EXMEM, SRC_REG}) begin
         errors++; $display("FAIL mfhi: got h=%b l=%b want h=01 l=00", bus.ALUSrcH, bus.ALUSrcL);
      end
      step();
      clear_inputs();
      step();
      step();
      set_ex(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_ex(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if ({bus.ALUSrcL, bus.ALUSrcH} !== {SRC_WB, SRC_REG}) begin
         errors++; $display("FAIL mflo: got l=%b h=%b want l=10 h=00", bus.ALUSrcL, bus.ALUSrcH);
      end
      step();
      clear_inputs();
      step();
      step();
   endtask

   task automatic test_reset_in_lstall();
      set_ex(5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
      set_id(5'd8, 5'd0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
         errors++; $display("FAIL rst_lstall_pre: got %b want 1", bus.Stall);
      end
      step();
      Reset = 1'b1;
      set_ex(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      Reset = 1'b0;
      set_ex(5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_id(5'd0, 5'd0, 1'b0, 1'b0);
      exp_cnt = 32'd0;
      #1;
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUSrcH, bus.ALUSrcL, bus.Stall, bus.Bubble} !== 10'd0) begin
         errors++; $display("FAIL rst_lstall_out: got %b want 0000000000",
                            {bus.ALUSrcA, bus.ALUSrcB, bus.ALUSrcH, bus.ALUSrcL, bus.Stall, bus.Bubble});
      end
      checks++;
      if (bus.StallCnt !== exp_cnt) begin
         errors++; $display("FAIL rst_lstall_cnt: got %0d want 0", bus.StallCnt);
      end
      step();
      #1;
      checks++;
      if ({bus.ALUSrcA, bus.ALUSrcB} !== 4'b0000) begin
         errors++; $display("FAIL rst_lstall_w: got %b want 0000", {bus.ALUSrcA, bus.ALUSrcB});
      end
      // FSM must be back in RUN: a fresh hazard stalls immediately.
      set_ex(5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      set_id(5'd8, 5'd0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
         errors++; $display("FAIL rst_lstall_rearm: got %b want 1", bus.Stall);
      end
      step();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_exmem_fwd();
      test_wb_fwd();
      test_priority();
      test_load_use();
      test_lstall_suppress();
      test_back_to_back();
      test_hilo();
      test_reset_in_lstall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
